// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: datapath, control FSM, req/ready memory port,
// start/halt protocol, retired-instruction counter and debug register read port.
module mips_multicycle_core #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [CNT_WIDTH-1:0]  retire_cnt,
    input  logic [4:0]            dbg_raddr,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DW-1:0]         ir_q, a_q, b_q, alu_q, mdr_q;
    logic [DW-1:0]         rf_q [32];
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [5:0]    op, funct;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] simm, zimm, alu_d;
    logic          fn_ok_d;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign simm  = {{(DW-16){ir_q[15]}}, ir_q[15:0]};
    assign zimm  = {{(DW-16){1'b0}}, ir_q[15:0]};

    always_comb begin
        alu_d   = '0;
        fn_ok_d = 1'b1;
        case (funct)
            6'b100000: alu_d = a_q + b_q;
            6'b100010: alu_d = a_q - b_q;
            6'b100100: alu_d = a_q & b_q;
            6'b100101: alu_d = a_q | b_q;
            6'b101010: alu_d = {{(DW-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            default:   fn_ok_d = 1'b0;
        endcase
    end

    // Address/data come straight from registers, so they hold through waits.
    assign mem_req    = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);
    assign mem_we     = (state_q == S_MEMWR);
    assign mem_addr   = (state_q == S_FETCH) ? pc_q : alu_q[ADDR_WIDTH-1:0];
    assign mem_wdata  = b_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted     = (state_q == S_HALT);
    assign pc_out     = pc_q;
    assign retire_cnt = cnt_q;
    assign dbg_rdata  = (dbg_raddr == 5'd0) ? '0 : rf_q[dbg_raddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    pc_q    <= start_addr;
                    state_q <= S_FETCH;
                end
                S_FETCH: if (mem_ready) begin
                    ir_q    <= mem_rdata;
                    pc_q    <= pc_q + ADDR_WIDTH'(4);
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    a_q   <= rf_q[rs];
                    b_q   <= rf_q[rt];
                    alu_q <= DW'(pc_q) + (simm << 2);
                    case (op)
                        6'b000000:            state_q <= S_EXEC;
                        6'b100011, 6'b101011: state_q <= S_MEMADR;
                        6'b001000, 6'b001101: state_q <= S_IMMEX;
                        6'b000100:            state_q <= S_BRANCH;
                        6'b000010:            state_q <= S_JUMP;
                        default:              state_q <= S_HALT;
                    endcase
                end
                S_EXEC: begin
                    alu_q   <= alu_d;
                    state_q <= fn_ok_d ? S_ALUWB : S_HALT;
                end
                S_ALUWB: begin
                    if (rd != 5'd0) rf_q[rd] <= alu_q;
                    cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    state_q <= S_FETCH;
                end
                // op[3] separates sw (101011) from lw (100011)
                S_MEMADR: begin
                    alu_q   <= a_q + simm;
                    state_q <= op[3] ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: if (mem_ready) begin
                    mdr_q   <= mem_rdata;
                    state_q <= S_MEMWB;
                end
                S_MEMWB: begin
                    if (rt != 5'd0) rf_q[rt] <= mdr_q;
                    cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    state_q <= S_FETCH;
                end
                S_MEMWR: if (mem_ready) begin
                    cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    state_q <= S_FETCH;
                end
                S_IMMEX: begin
                    alu_q   <= op[0] ? (a_q | zimm) : (a_q + simm);
                    state_q <= S_IMMWB;
                end
                S_IMMWB: begin
                    if (rt != 5'd0) rf_q[rt] <= alu_q;
                    cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    state_q <= S_FETCH;
                end
                S_BRANCH: begin
                    if (a_q == b_q) pc_q <= alu_q[ADDR_WIDTH-1:0];
                    cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    state_q <= S_FETCH;
                end
                S_JUMP: begin
                    pc_q    <= ADDR_WIDTH'({ir_q[25:0], 2'b00});
                    cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    state_q <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: ISA-level reference model with wait-state
// memory responder, per-cycle output comparison and directed literal checks.
module tb_mips_multicycle_core;
    localparam logic [15:0] CODE = 16'h1000;
    localparam int          CB   = 32'h400;
    localparam int          NP   = 120;

    logic        clk = 1'b0;
    logic        rst, start, mem_req, mem_we, mem_ready, busy, halted;
    logic [15:0] start_addr, mem_addr, pc_out;
    logic [31:0] mem_wdata, mem_rdata, retire_cnt, dbg_rdata;
    logic [4:0]  dbg_raddr;

    int errors = 0;
    int checks = 0;

    logic [31:0] bmem [16384];
    logic [31:0] mmem [16384];

    logic [31:0] mregs [32];
    logic [15:0] mpc, pc_start;
    logic [31:0] mcnt, ir;
    bit          running, mhalt;
    int          t, lat, cur_wf, wmode;
    int          wq [$];

    bit          rst_s, st_s;
    logic [15:0] sa_s;
    bit          have;
    int          cur_w;
    logic [15:0] h_addr;
    logic        h_we;
    logic [31:0] h_wd;

    always #5 clk = ~clk;

    assign mem_rdata = bmem[mem_addr[15:2]];

    mips_multicycle_core dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .halted(halted), .pc_out(pc_out),
        .retire_cnt(retire_cnt), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [31:0] w);
        bmem[a[15:2]] = w;
        mmem[a[15:2]] = w;
    endtask

    function automatic int pick_wait(input bit data);
        case (wmode)
            0:       return 0;
            1:       return data ? 3 : 0;
            2:       return $urandom_range(0, 2);
            default: return (!data && mcnt >= 1) ? 50 : 0;
        endcase
    endfunction

    function automatic logic [15:0] vis_pc();
        if (running && !mhalt)
            return (t <= cur_wf) ? pc_start : pc_start + 16'd4;
        return mpc;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mpc = '0; mcnt = '0; running = 0; mhalt = 0; t = 0;
        wq.delete();
        have = 0;
    endtask

    task automatic start_instr();
        int wd;
        logic [5:0] op, fn;
        ir = mmem[mpc[15:2]];
        pc_start = mpc;
        t = 0;
        op = ir[31:26];
        fn = ir[5:0];
        cur_wf = pick_wait(0);
        wq.push_back(cur_wf);
        wd = 0;
        if (op == 6'h23 || op == 6'h2B) begin
            wd = pick_wait(1);
            wq.push_back(wd);
        end
        case (op)
            6'h00: lat = (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? 4 : 3;
            6'h23: lat = 5;
            6'h2B, 6'h08, 6'h0D: lat = 4;
            6'h04, 6'h02: lat = 3;
            default: lat = 2;
        endcase
        lat += cur_wf + wd;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 0) mregs[idx] = v;
    endtask

    task automatic execute();
        logic [31:0] a, b, simm;
        logic [15:0] ea, npc;
        bit ok;
        a = mregs[ir[25:21]];
        b = mregs[ir[20:16]];
        simm = {{16{ir[15]}}, ir[15:0]};
        ea = 16'(a + simm);
        npc = pc_start + 16'd4;
        ok = 1;
        case (ir[31:26])
            6'h00: case (ir[5:0])
                6'h20: wr(ir[15:11], a + b);
                6'h22: wr(ir[15:11], a - b);
                6'h24: wr(ir[15:11], a & b);
                6'h25: wr(ir[15:11], a | b);
                6'h2A: wr(ir[15:11], ($signed(a) < $signed(b)) ? 1 : 0);
                default: ok = 0;
            endcase
            6'h23: wr(ir[20:16], mmem[ea[15:2]]);
            6'h2B: mmem[ea[15:2]] = b;
            6'h08: wr(ir[20:16], a + simm);
            6'h0D: wr(ir[20:16], a | {16'h0, ir[15:0]});
            6'h04: if (a == b) npc = npc + 16'(simm << 2);
            6'h02: npc = 16'({ir[25:0], 2'b00});
            default: ok = 0;
        endcase
        mpc = npc;
        if (ok) begin
            mcnt++;
            start_instr();
        end else begin
            mhalt = 1;
        end
    endtask

    always @(posedge clk) begin
        rst_s = rst;
        st_s  = start;
        sa_s  = start_addr;
        if (mem_req && mem_ready && mem_we && !rst)
            bmem[mem_addr[15:2]] = mem_wdata;
    end

    // Model advance for the edge just past, output compare, then responder.
    always @(negedge clk) begin
        if (rst_s) begin
            model_reset();
        end else if (!running && st_s) begin
            running = 1;
            mpc = sa_s;
            start_instr();
        end else if (running && !mhalt) begin
            t++;
            if (t == lat) execute();
        end
        chk("busy", busy, running && !mhalt);
        chk("halted", halted, mhalt);
        chk("retire_cnt", retire_cnt, mcnt);
        chk("pc_out", pc_out, vis_pc());
        chk("dbg_rdata", dbg_rdata, (dbg_raddr == 0) ? 32'h0 : mregs[dbg_raddr]);
        if (!(running && !mhalt)) chk("mem_req_idle", mem_req, 0);
        if (mem_req) begin
            if (!have) begin
                if (wq.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                    cur_w = 0;
                end else begin
                    cur_w = wq.pop_front();
                end
                have = 1;
                h_addr = mem_addr;
                h_we = mem_we;
                h_wd = mem_wdata;
            end else begin
                chk("hold_addr", mem_addr, h_addr);
                chk("hold_we", mem_we, h_we);
                if (h_we) chk("hold_wdata", mem_wdata, h_wd);
            end
            if (cur_w > 0) begin
                mem_ready = 1'b0;
                cur_w--;
            end else begin
                mem_ready = 1'b1;
                have = 0;
            end
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic pulse_start(input logic [15:0] a);
        @(posedge clk); #2;
        start = 1'b1;
        start_addr = a;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic do_rst();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic wait_cnt(input logic [31:0] n);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (mcnt >= n) break;
        end
        if (mcnt < n) chk("wait_timeout", mcnt, n);
    endtask

    task automatic lit_reg(input string nm, input logic [4:0] idx,
                           input logic [31:0] exp);
        dbg_raddr = idx;
        #1;
        chk(nm, dbg_rdata, exp);
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [5:0] fn_pick(input int k);
        case (k)
            0: return 6'h20;
            1: return 6'h22;
            2: return 6'h24;
            3: return 6'h25;
            default: return 6'h2A;
        endcase
    endfunction

    task automatic gen_prog();
        int r, room;
        logic [4:0] rs, rt, rd;
        logic [31:0] w;
        for (int i = 0; i < 32; i++) put(16'h0800 + 16'(4 * i), $urandom);
        for (int i = 0; i < NP; i++) begin
            r = $urandom_range(0, 99);
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            room = NP - 1 - i;
            if (r < 28)
                w = {6'h0, rs, rt, rd, 5'h0, (r == 0) ? 6'h00 : fn_pick($urandom_range(0, 4))};
            else if (r < 45) w = itype(6'h08, rs, rt, 16'($urandom));
            else if (r < 55) w = itype(6'h0D, rs, rt, 16'($urandom));
            else if (r < 65) w = itype(6'h2B, 5'd0, rt, 16'(16'h0800 + 4 * $urandom_range(0, 31)));
            else if (r < 75) w = itype(6'h23, 5'd0, rt, 16'(16'h0800 + 4 * $urandom_range(0, 31)));
            else if (r < 88) w = itype(6'h04, rs, rt, 16'($urandom_range(0, room)));
            else if (r < 99) w = {6'h02, 26'(CB + i + 1 + $urandom_range(0, room))};
            else w = 32'hFC000000 | 32'($urandom_range(0, 255));
            put(CODE + 16'(4 * i), w);
        end
        put(CODE + 16'(4 * NP), 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; dbg_raddr = '0;
        mem_ready = 1'b0; wmode = 0;
        model_reset();
        for (int i = 0; i < 16384; i++) begin
            bmem[i] = '0;
            mmem[i] = '0;
        end
        put(16'h0040, 32'h20010005);
        put(16'h0044, 32'h2002FFFD);
        put(16'h0048, 32'h00221820);
        put(16'h004C, 32'h0041202A);
        put(16'h0050, 32'h00412822);
        put(16'h0054, 32'h00210020);
        put(16'h0058, 32'hAC010008);
        put(16'h005C, 32'h8C060008);
        put(16'h0060, 32'h10220005);
        put(16'h0064, 32'h3427F0F0);
        put(16'h0068, 32'h08000020);
        put(16'h0080, 32'h1021FFFF);
        put(16'h0090, 32'hFC000000);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset_cnt", retire_cnt, 0);
        chk("reset_pc", pc_out, 0);

        wmode = 1;
        pulse_start(16'h0040);
        repeat (4) @(posedge clk);
        #3;
        chk("t1_cnt", retire_cnt, 1);
        chk("t1_pc", pc_out, 16'h0044);
        lit_reg("t1_r1", 5'd1, 32'd5);

        wait_cnt(6);
        lit_reg("t2_add", 5'd3, 32'd2);
        lit_reg("t2_slt", 5'd4, 32'd1);
        lit_reg("t2_sub", 5'd5, 32'hFFFFFFF8);
        wait_cnt(8);
        lit_reg("t3_lw", 5'd6, 32'd5);
        chk("t3_mem", bmem[2], 32'd5);
        wait_cnt(9);
        chk("t4_nt_pc", pc_out, 16'h0064);
        wait_cnt(10);
        lit_reg("ori", 5'd7, 32'h0000F0F5);
        wait_cnt(12);
        chk("t4_loop_pc", pc_out, 16'h0080);
        repeat (3) @(negedge clk);
        #1;
        chk("t4_loop_cnt", retire_cnt, 13);
        chk("t4_loop_pc2", pc_out, 16'h0080);

        do_rst();
        #1;
        chk("rst_cnt", retire_cnt, 0);
        pulse_start(16'h0090);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_halted", halted, 1);
        chk("t5_busy", busy, 0);
        chk("t5_req", mem_req, 0);
        chk("t5_pc", pc_out, 16'h0094);
        pulse_start(16'h0040);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_sticky", halted, 1);
        chk("t5_cnt", retire_cnt, 0);
        do_rst();
        #1;
        chk("t5_rst", halted, 0);

        wmode = 3;
        pulse_start(16'h0040);
        wait_cnt(1);
        repeat (2) @(negedge clk);
        do_rst();
        #1;
        chk("t6_req", mem_req, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", retire_cnt, 0);
        lit_reg("t6_r1", 5'd1, 32'd0);

        wmode = 2;
        for (int p = 0; p < 4; p++) begin
            gen_prog();
            do_rst();
            pulse_start(CODE);
            for (int k = 0; k < 6000 && !mhalt; k++) begin
                @(posedge clk); #2;
                start = 1'($urandom_range(0, 1));
                start_addr = 16'($urandom);
                dbg_raddr = 5'($urandom);
            end
            start = 1'b0;
            chk("prog_halt", mhalt, 1);
            for (int i = 0; i < 32; i++)
                chk("data_mem", bmem[512 + i], mmem[512 + i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
